// File: rtl/apb_regbank_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_regbank_slave
// Brief    : APB register bank: ID, CTRL, STATUS and general RW registers,
//            with programmable wait states and error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module apb_regbank_slave #(
  parameter int          DATA_W      = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hDEADBEEF
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int         c_strb_w   = DATA_W / 8;
  localparam logic [3:0] c_wait     = 4'(WAIT_CYCLES);
  localparam logic [5:0] c_idx_id   = 6'd0;
  localparam logic [5:0] c_idx_ctrl = 6'd1;
  localparam logic [5:0] c_idx_stat = 6'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_err_flag;
  logic [7:0]          r_err_cnt;

  logic [5:0]          w_idx;
  logic                w_access;
  logic                w_ready;
  logic                w_err;
  logic                w_commit;
  logic                w_rd_ok;
  logic                w_clear;
  logic [DATA_W-1:0]   w_sel;
  logic [DATA_W-1:0]   w_status;
  logic                w_unused_addr;

  assign w_unused_addr = ^PADDR[31:8];
  assign w_idx         = PADDR[7:2];

  // An access phase is recognised from the bus alone, so a transfer that
  // skips its setup phase is still served in the cycle it appears.
  assign w_access = PSEL & PENABLE;
  assign w_ready  = PRESETn & w_access & (r_cnt == c_wait);
  assign w_err    = (PADDR[1:0] != 2'b00)
                  | ({1'b0, w_idx} >= 7'(NUM_REGS))
                  | (PWRITE & ((w_idx == c_idx_id) | (w_idx == c_idx_stat)));
  assign w_commit = w_ready & ~w_err & PWRITE;
  assign w_rd_ok  = w_ready & ~w_err & ~PWRITE;
  assign w_clear  = w_commit & (w_idx == c_idx_ctrl) & PWDATA[DATA_W-1] & PSTRB[c_strb_w-1];

  assign PREADY  = w_ready;
  assign PSLVERR = w_ready & w_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_ready) w_state_nxt = PSEL ? ST_SETUP : ST_IDLE;
          else         w_state_nxt = ST_ACCESS;
        end else if (PSEL) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (w_ready) w_state_nxt = PSEL ? ST_SETUP : ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= 4'd0;
    end else if (w_ready || !w_access) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // ID and STATUS slots of the array are never written and stay zero.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_idx == 6'(i) && i != 0 && i != 2) begin
            for (int b = 0; b < c_strb_w; b++) begin
              if (PSTRB[b]) r_regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
            end
          end
        end
      end
      // CTRL[31] is a self-clearing command bit and is never stored.
      r_regs[1][DATA_W-1] <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else if (w_clear) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else if (PSLVERR) begin
      r_err_flag <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign w_status = {{(DATA_W-16){1'b0}}, r_err_cnt, 6'b000000, r_err_flag, r_regs[1][0]};

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == 6'(i)) w_sel = r_regs[i];
    end
  end

  always_comb begin
    PRDATA = '0;
    if (w_rd_ok) begin
      if (w_idx == c_idx_id)        PRDATA = DATA_W'(ID_VALUE);
      else if (w_idx == c_idx_stat) PRDATA = w_status;
      else                          PRDATA = w_sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_regbank_slave
// Brief    : Self-checking bench for apb_regbank_slave with 0, 3 and 5 wait
//            states; reference model plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regbank_slave;

  logic        clk;
  logic        rst_n;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int n_checks = 0;
  int n_fail   = 0;

  apb_regbank_slave #(.DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(32'hDEADBEEF)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_regbank_slave #(.DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(3), .ID_VALUE(32'hDEADBEEF)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_regbank_slave #(.DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(5), .ID_VALUE(32'hDEADBEEF)) u_dut2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg  [3][8];
  logic        m_flag [3];
  logic [7:0]  m_cnt  [3];
  int          m_acc  [3];

  function automatic logic [31:0] m_read(input int d, input int idx);
    if (idx == 0) return 32'hDEADBEEF;
    if (idx == 2) return {16'h0, m_cnt[d], 6'b0, m_flag[d], m_reg[d][1][0]};
    return m_reg[d][idx];
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        for (int r = 0; r < 8; r++) m_reg[d][r] = 32'h0;
        m_flag[d] = 1'b0;
        m_cnt[d]  = 8'h0;
        m_acc[d]  = 0;
        chk("rst_pready", {31'b0, pready[d]}, 32'h0);
        chk("rst_pslverr", {31'b0, pslverr[d]}, 32'h0);
        chk("rst_prdata", prdata[d], 32'h0);
      end else if (psel[d] && penable[d]) begin
        if (m_acc[d] == wait_of(d)) begin
          int  idx;
          bit  err;
          idx = int'(paddr[d][7:2]);
          err = (paddr[d][1:0] != 2'b00) || (idx >= 8) ||
                (pwrite[d] && (idx == 0 || idx == 2));
          chk("mdl_pready", {31'b0, pready[d]}, 32'h1);
          chk("mdl_pslverr", {31'b0, pslverr[d]}, {31'b0, err});
          chk("mdl_prdata", prdata[d], (!pwrite[d] && !err) ? m_read(d, idx) : 32'h0);
          if (err) begin
            m_flag[d] = 1'b1;
            if (m_cnt[d] != 8'hFF) m_cnt[d] = m_cnt[d] + 8'd1;
          end else if (pwrite[d]) begin
            for (int b = 0; b < 4; b++)
              if (pstrb[d][b]) m_reg[d][idx][8*b +: 8] = pwdata[d][8*b +: 8];
            if (idx == 1) begin
              if (pwdata[d][31] && pstrb[d][3]) begin
                m_flag[d] = 1'b0;
                m_cnt[d]  = 8'h0;
              end
              m_reg[d][1][31] = 1'b0;
            end
          end
          m_acc[d] = 0;
        end else begin
          chk("mdl_wait_pready", {31'b0, pready[d]}, 32'h0);
          chk("mdl_wait_pslverr", {31'b0, pslverr[d]}, 32'h0);
          chk("mdl_wait_prdata", prdata[d], 32'h0);
          m_acc[d] = m_acc[d] + 1;
        end
      end else begin
        chk("mdl_idle_pready", {31'b0, pready[d]}, 32'h0);
        chk("mdl_idle_prdata", prdata[d], 32'h0);
        m_acc[d] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input bit skip_setup,
                      output logic [31:0] rd, output logic err, output int waits);
    @(posedge clk); #1;
    psel[d] = 1'b1; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    penable[d] = skip_setup;
    if (!skip_setup) begin
      @(posedge clk); #1;
      penable[d] = 1'b1;
    end
    waits = 0; rd = 32'h0; err = 1'b0;
    forever begin
      @(negedge clk);
      if (pready[d]) begin
        rd  = prdata[d];
        err = pslverr[d];
        break;
      end
      waits++;
      if (waits > 40) begin
        chk("xfer_timeout", 32'(waits), 32'(wait_of(d)));
        break;
      end
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic wr_chk(input int d, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic exp_err, input string name);
    logic [31:0] rd; logic err; int w;
    xfer(d, 1'b1, addr, data, strb, 1'b0, rd, err, w);
    chk(name, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic rd_chk(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic exp_err, input string name);
    logic [31:0] rd; logic err; int w;
    xfer(d, 1'b0, addr, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk(name, rd, exp_data);
    chk({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0; pwdata[d] = 0; pstrb[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // zero-wait read of ID, with and without a setup phase
    xfer(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("id_waits", 32'(w), 32'd0);
    chk("id_data", rd, 32'hDEADBEEF);
    chk("id_err", {31'b0, err}, 32'h0);
    xfer(0, 1'b0, 32'hFFFF_FF00, 32'h0, 4'h0, 1'b1, rd, err, w);
    chk("id_nosetup_waits", 32'(w), 32'd0);
    chk("id_nosetup_data", rd, 32'hDEADBEEF);

    // three wait states: CTRL write then STATUS read
    xfer(1, 1'b1, 32'h04, 32'h0000_0001, 4'hF, 1'b0, rd, err, w);
    chk("w3_write_waits", 32'(w), 32'd3);
    chk("w3_write_err", {31'b0, err}, 32'h0);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("w3_status_waits", 32'(w), 32'd3);
    chk("w3_status_data", rd, 32'h0000_0001);

    // byte strobes
    wr_chk(0, 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, "gpr_full_err");
    wr_chk(0, 32'h10, 32'h1234_5678, 4'b0101, 1'b0, "gpr_strb_err");
    rd_chk(0, 32'h10, 32'hFF34_FF78, 1'b0, "gpr_strb_data");
    wr_chk(0, 32'h1C, 32'hAAAA_AAAA, 4'h0, 1'b0, "gpr_nostrb_err");
    rd_chk(0, 32'h1C, 32'h0000_0000, 1'b0, "gpr_nostrb_data");
    wr_chk(0, 32'h1C, 32'hCAFE_F00D, 4'hF, 1'b0, "gpr_top_err");
    rd_chk(0, 32'h1C, 32'hCAFE_F00D, 1'b0, "gpr_top_data");

    // error sources and sticky status
    wr_chk(0, 32'h08, 32'h0000_FFFF, 4'hF, 1'b1, "err_wr_status");
    rd_chk(0, 32'h22, 32'h0, 1'b1, "err_unaligned");
    rd_chk(0, 32'h20, 32'h0, 1'b1, "err_range");
    rd_chk(0, 32'h08, 32'h0000_0302, 1'b0, "status_after_err");

    // clear via CTRL[31]
    wr_chk(0, 32'h04, 32'h8000_0000, 4'hF, 1'b0, "clear_err");
    rd_chk(0, 32'h08, 32'h0000_0000, 1'b0, "status_cleared");
    rd_chk(0, 32'h04, 32'h0000_0000, 1'b0, "ctrl_after_clear");
    wr_chk(0, 32'h04, 32'hFFFF_FFFF, 4'b0111, 1'b0, "ctrl_partial_err");
    rd_chk(0, 32'h04, 32'h00FF_FFFF, 1'b0, "ctrl_partial_data");

    // error counter saturation
    for (int i = 0; i < 260; i++) xfer(0, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1, rd, err, w);
    rd_chk(0, 32'h08, 32'h0000_FF03, 1'b0, "status_saturated");
    wr_chk(0, 32'h00, 32'h1, 4'hF, 1'b1, "err_wr_id");
    rd_chk(0, 32'h08, 32'h0000_FF03, 1'b0, "status_still_sat");

    // reset in the middle of a 5-wait write
    @(posedge clk); #1;
    psel[2] = 1'b1; pwrite[2] = 1'b1; paddr[2] = 32'h0C; pwdata[2] = 32'hA5A5_A5A5; pstrb[2] = 4'hF;
    penable[2] = 1'b0;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrst_pready", {31'b0, pready[2]}, 32'h0);
    repeat (2) @(posedge clk);
    #1 psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, rd, err, w);
    chk("post_rst_waits", 32'(w), 32'd5);
    chk("post_rst_data", rd, 32'h0000_0000);
    chk("post_rst_err", {31'b0, err}, 32'h0);
    rd_chk(0, 32'h10, 32'h0000_0000, 1'b0, "post_rst_gpr0");
    rd_chk(0, 32'h08, 32'h0000_0000, 1'b0, "post_rst_status0");
    rd_chk(1, 32'h04, 32'h0000_0000, 1'b0, "post_rst_ctrl1");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
